// File: rtl/iq_sample_packer.sv
// Decimates 3-bit I/Q samples, packs five pairs plus a 2-bit sequence tag per 32-bit word,
// and streams words out through a FIFO. Define IQ_PACKER_TEST_PATTERN_EN to pack a counter instead.
module iq_sample_packer #(
  parameter int FIFO_DEPTH = 16,
  parameter int DECIM_W    = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          enable,
  input  logic [DECIM_W-1:0]            decim,
  input  logic [2:0]                    real_in,
  input  logic [2:0]                    imag_in,
  output logic [31:0]                   m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic [15:0]                   overflow_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [DECIM_W-1:0] dcnt;
  logic [2:0]         pidx;
  logic [23:0]        partial;
  logic [1:0]         seq;
  logic               push_pend;
  logic [31:0]        push_word;
  logic [5:0]         sample;
  logic               take;

  logic [31:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [LW-1:0]      count;
  logic               full;
  logic               pop;
  logic               accept;
  logic               drop;

  assign take = enable && (dcnt == '0);

`ifdef IQ_PACKER_TEST_PATTERN_EN
  logic [5:0] tp_cnt;

  always_ff @(posedge clk) begin
    if (!rstn || !enable) tp_cnt <= '0;
    else if (take)        tp_cnt <= tp_cnt + 6'd1;
  end

  assign sample = tp_cnt;
`else
  assign sample = {real_in, imag_in};
`endif

  // Samples shift in from the top, so after four shifts sample 0 sits in bits [5:0]
  // and the fifth sample completes the word without any indexed writes.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      dcnt      <= '0;
      pidx      <= '0;
      partial   <= '0;
      seq       <= '0;
      push_pend <= 1'b0;
      push_word <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register sees pre-edge values of the others.
      push_pend <= 1'b0;
      if (!enable) begin
        dcnt    <= '0;
        pidx    <= '0;
        partial <= '0;
      end else begin
        dcnt <= (dcnt >= decim) ? '0 : dcnt + 1'b1;
        if (take) begin
          if (pidx == 3'd4) begin
            push_word <= {seq, sample, partial};
            push_pend <= 1'b1;
            seq       <= seq + 2'd1;
            pidx      <= '0;
            partial   <= '0;
          end else begin
            partial <= {sample, partial[23:6]};
            pidx    <= pidx + 3'd1;
          end
        end
      end
    end
  end

  assign full   = (count == LW'(FIFO_DEPTH));
  assign pop    = m_tvalid && m_tready;
  assign accept = push_pend && (!full || pop);
  assign drop   = push_pend && full && !pop;

  // NOTE: the storage array has no reset; occupancy is tracked by count, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      overflow_count <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      count <= count + LW'(accept) - LW'(pop);
      if (drop && overflow_count != 16'hFFFF) overflow_count <= overflow_count + 16'd1;
    end
  end

  assign m_tvalid   = (count != '0);
  assign m_tdata    = m_tvalid ? mem[rd_ptr] : '0;
  assign fifo_level = count;

endmodule

// File: tb/tb_iq_sample_packer.sv
// Randomized bench for iq_sample_packer: a queue-based model of decimation, packing and the
// output FIFO is compared against the DUT after every clock edge, plus literal spot checks.
module tb_iq_sample_packer;

  localparam int DEPTH   = 16;
  localparam int DECIM_W = 8;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 enable;
  logic [DECIM_W-1:0]   decim;
  logic [2:0]           real_in;
  logic [2:0]           imag_in;
  logic [31:0]          m_tdata;
  logic                 m_tvalid;
  logic                 m_tready;
  logic [15:0]          overflow_count;
  logic [$clog2(DEPTH):0] fifo_level;

  iq_sample_packer #(.FIFO_DEPTH(DEPTH), .DECIM_W(DECIM_W)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .decim(decim),
    .real_in(real_in), .imag_in(imag_in),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .overflow_count(overflow_count), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [31:0] fifo_q[$];
  int          samp_q[$];
  int          cyc = 0;
  bit          fresh = 1'b1;
  int          last_take = 0;
  int          dec_prev = 0;
  bit          pend_v = 1'b0;
  logic [31:0] pend_w = '0;
  int          ovf_m = 0;
  int          seq_m = 0;
  int          tp_m = 0;
  int          ramp = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // A sample is due on the first enabled cycle after reset/disable, otherwise once more than
  // decim enabled cycles (decim as seen one cycle earlier) have passed since the previous take.
  task automatic model_edge();
    bit pop, full;
    int s;
    logic [31:0] w;
    if (!rstn) begin
      fifo_q.delete();
      samp_q.delete();
      fresh = 1'b1;
      pend_v = 1'b0;
      ovf_m = 0;
      seq_m = 0;
      tp_m = 0;
    end else begin
      pop  = (fifo_q.size() > 0) && m_tready;
      full = (fifo_q.size() == DEPTH);
      if (pop) void'(fifo_q.pop_front());
      if (pend_v) begin
        if (!full || pop) fifo_q.push_back(pend_w);
        else if (ovf_m < 65535) ovf_m++;
      end
      pend_v = 1'b0;
      if (!enable) begin
        samp_q.delete();
        tp_m = 0;
        fresh = 1'b1;
      end else if (fresh || (cyc - 1 - last_take) >= dec_prev) begin
        fresh = 1'b0;
        last_take = cyc;
`ifdef IQ_PACKER_TEST_PATTERN_EN
        s = tp_m;
`else
        s = {26'd0, real_in, imag_in};
`endif
        tp_m = (tp_m + 1) % 64;
        samp_q.push_back(s);
        if (samp_q.size() == 5) begin
          w = 32'(seq_m) << 30;
          for (int k = 0; k < 5; k++) w = w | (32'(samp_q[k]) << (6 * k));
          pend_v = 1'b1;
          pend_w = w;
          seq_m = (seq_m + 1) % 4;
          samp_q.delete();
        end
      end
    end
    dec_prev = int'(decim);
    cyc++;
  endtask

  task automatic compare();
    check("m_tvalid", {31'd0, m_tvalid}, {31'd0, fifo_q.size() > 0});
    check("fifo_level", 32'(fifo_level), 32'(fifo_q.size()));
    check("overflow_count", 32'(overflow_count), 32'(ovf_m));
    if (fifo_q.size() > 0) check("m_tdata", m_tdata, fifo_q[0]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic step_ramp(input int n);
    for (int i = 0; i < n; i++) begin
      {real_in, imag_in} = 6'(ramp);
      ramp++;
      step();
    end
  endtask

  initial begin
    rstn = 1'b0; enable = 1'b0; decim = '0;
    real_in = '0; imag_in = '0; m_tready = 1'b0;
    step();
    step();
    check("reset m_tdata", m_tdata, 32'h0);
    check("reset m_tvalid", {31'd0, m_tvalid}, 32'd0);

    // Constant pattern, decim=0: first word visible two cycles after its 5th sample.
    rstn = 1'b1; enable = 1'b1; real_in = 3'b101; imag_in = 3'b010; m_tready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("latency no early valid", {31'd0, m_tvalid}, 32'd0);
    step();
    check("first word valid", {31'd0, m_tvalid}, 32'd1);
`ifndef IQ_PACKER_TEST_PATTERN_EN
    check("first word", m_tdata, 32'h2AAAAAAA);
`endif
    for (int i = 0; i < 5; i++) step();
`ifndef IQ_PACKER_TEST_PATTERN_EN
    check("second word", m_tdata, 32'h6AAAAAAA);
`endif

    // Decimation by 4 on a ramp, then reduced to 2 mid-run.
    decim = 8'd3;
    step_ramp(45);
    decim = 8'd1;
    step_ramp(25);

    // Overflow: downstream stalled, FIFO fills, later words dropped.
    rstn = 1'b0; m_tready = 1'b0; real_in = 3'b011; imag_in = 3'b110; decim = '0;
    step();
    rstn = 1'b1;
    for (int i = 0; i < 100; i++) step();
    check("full level", 32'(fifo_level), 32'd16);
    check("overflow after 3 drops", 32'(overflow_count), 32'd3);
    m_tready = 1'b1;
    step();
    m_tready = 1'b0;
    check("push+pop on full keeps level", 32'(fifo_level), 32'd16);
    check("push+pop on full no drop", 32'(overflow_count), 32'd3);
    for (int i = 0; i < 7; i++) step();
    enable = 1'b0; m_tready = 1'b1;
    for (int i = 0; i < 10; i++) step();

    // Reset mid-stream with queued words and a nonzero drop count.
    m_tready = 1'b0; enable = 1'b1;
    step_ramp(23);
    rstn = 1'b0;
    step();
    check("mid reset m_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("mid reset level", 32'(fifo_level), 32'd0);
    check("mid reset overflow", 32'(overflow_count), 32'd0);
    rstn = 1'b1;
    step_ramp(6);
    check("seq after reset", {30'd0, m_tdata[31:30]}, 32'd0);

    // Enable dropped after 3 samples of a partial word, then re-enabled.
    step_ramp(8);
    enable = 1'b0;
    step_ramp(3);
    enable = 1'b1;
    step_ramp(12);
    m_tready = 1'b1;
    step_ramp(10);

    // Randomized traffic with occasional resets, disables and decim changes.
    for (int i = 0; i < 4000; i++) begin
      rstn     = ($urandom_range(0, 499) != 0);
      enable   = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 29) == 0) decim = 8'($urandom_range(0, 3));
      m_tready = ($urandom_range(0, 2) != 0);
      real_in  = 3'($urandom);
      imag_in  = 3'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
